// File: rtl/dma_controller.sv
// Single-channel DMA engine: copies a block of words from memory to an
// accelerator, one READ cycle and one WRITE cycle per word. Every output
// is driven from a flop, so the outputs for the next cycle are decided
// from the next state in the combinational block.
module dma_controller #(
    parameter int BYTES_PER_WORD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_transfer,
    input  logic [31:0] src_addr,
    input  logic [31:0] dest_addr,
    input  logic [31:0] transfer_length,
    input  logic [31:0] mem_data_in,
    output logic        dma_busy,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_data_out,
    output logic [31:0] acc_addr,
    output logic        acc_read,
    output logic        acc_write,
    output logic [31:0] acc_data_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [31:0] BPW = 32'(BYTES_PER_WORD);

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dest_q, dest_d;
    logic [31:0] words_q, words_d;
    logic [31:0] offset_q, offset_d;
    logic        busy_q, busy_d;
    logic        mem_read_q, mem_read_d;
    logic        acc_write_q, acc_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] acc_addr_q, acc_addr_d;
    logic [31:0] acc_data_q, acc_data_d;
    logic [31:0] words_calc;
    logic        start_edge;

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_d     = state_q;
        start_d     = start_transfer;
        src_d       = src_q;
        dest_d      = dest_q;
        words_d     = words_q;
        offset_d    = offset_q;
        busy_d      = 1'b0;
        mem_read_d  = 1'b0;
        acc_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        // Round a partial trailing word up to a whole word.
        words_calc  = (transfer_length / BPW)
                    + {31'd0, ((transfer_length % BPW) != 32'd0)};
        start_edge  = start_transfer && !start_q;

        case (state_q)
            IDLE: begin
                if (start_edge && (transfer_length != 32'd0)) begin
                    state_d    = READ;
                    src_d      = src_addr;
                    dest_d     = dest_addr;
                    words_d    = words_calc;
                    offset_d   = 32'd0;
                    busy_d     = 1'b1;
                    mem_read_d = 1'b1;
                    mem_addr_d = src_addr;
                end
            end
            READ: begin
                state_d     = WRITE;
                busy_d      = 1'b1;
                acc_write_d = 1'b1;
                acc_addr_d  = dest_q + offset_q;
                acc_data_d  = mem_data_in;
            end
            WRITE: begin
                offset_d = offset_q + BPW;
                words_d  = words_q - 32'd1;
                if (words_q > 32'd1) begin
                    state_d    = READ;
                    busy_d     = 1'b1;
                    mem_read_d = 1'b1;
                    mem_addr_d = src_q + offset_q + BPW;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched transfer context and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            src_q       <= 32'd0;
            dest_q      <= 32'd0;
            words_q     <= 32'd0;
            offset_q    <= 32'd0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            acc_write_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            acc_addr_q  <= 32'd0;
            acc_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            src_q       <= src_d;
            dest_q      <= dest_d;
            words_q     <= words_d;
            offset_q    <= offset_d;
            busy_q      <= busy_d;
            mem_read_q  <= mem_read_d;
            acc_write_q <= acc_write_d;
            mem_addr_q  <= mem_addr_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
        end
    end

    assign dma_busy     = busy_q;
    assign mem_addr     = mem_addr_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = 1'b0;
    assign mem_data_out = 32'd0;
    assign acc_addr     = acc_addr_q;
    assign acc_read     = 1'b0;
    assign acc_write    = acc_write_q;
    assign acc_data_out = acc_data_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed testbench for dma_controller: inputs driven and outputs
// sampled on the falling clock edge.
module tb_dma_controller;

    logic        clk;
    logic        reset;
    logic        start_transfer;
    logic [31:0] src_addr;
    logic [31:0] dest_addr;
    logic [31:0] transfer_length;
    logic [31:0] mem_data_in;
    logic        dma_busy;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic [31:0] acc_addr;
    logic        acc_read;
    logic        acc_write;
    logic [31:0] acc_data_out;

    int errors = 0;
    int checks = 0;

    dma_controller #(.BYTES_PER_WORD(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_transfer  (start_transfer),
        .src_addr        (src_addr),
        .dest_addr       (dest_addr),
        .transfer_length (transfer_length),
        .mem_data_in     (mem_data_in),
        .dma_busy        (dma_busy),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_data_out    (mem_data_out),
        .acc_addr        (acc_addr),
        .acc_read        (acc_read),
        .acc_write       (acc_write),
        .acc_data_out    (acc_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset = 1'b0;
        start_transfer = 1'b0;
        src_addr = 32'd0;
        dest_addr = 32'd0;
        transfer_length = 32'd0;
        mem_data_in = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dma_busy, mem_read, acc_write, mem_write, acc_read} !== 5'b0 ||
            mem_addr !== 32'd0 || acc_addr !== 32'd0 || acc_data_out !== 32'd0 ||
            mem_data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b rd=%b wr=%b maddr=%h aaddr=%h adata=%h, want all 0",
                     dma_busy, mem_read, acc_write, mem_addr, acc_addr, acc_data_out);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dma_busy, mem_read, acc_write} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy/rd/wr=%b, want 000",
                     {dma_busy, mem_read, acc_write});
        end
    endtask

    // One transfer: per-cycle check of strobes, addresses and data, then
    // trailing idle cycles with start still high.
    task automatic test_transfer(input string name, input logic [31:0] src,
                                 input logic [31:0] dest, input logic [31:0] len,
                                 input logic [31:0] data, input int nwords,
                                 input bit vary, input bit disturb, input int trail);
        logic [4:0]  exp_ctl;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        int          k;
        bit          odd;
        start_transfer = 1'b0;
        @(negedge clk);
        checks++;
        if (dma_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pre_idle: got busy=%b, want 0", name, dma_busy);
        end
        src_addr = src;
        dest_addr = dest;
        transfer_length = len;
        mem_data_in = data;
        start_transfer = 1'b1;
        for (int c = 1; c <= 2 * nwords; c++) begin
            @(negedge clk);
            k = (c - 1) / 2;
            odd = (c % 2) == 1;
            exp_ctl = {1'b1, odd, !odd, 1'b0, 1'b0};
            checks++;
            if ({dma_busy, mem_read, acc_write, mem_write, acc_read} !== exp_ctl ||
                mem_data_out !== 32'd0) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got busy,rd,wr,mwr,ard=%b dout=%h, want %b dout=0",
                         name, c, {dma_busy, mem_read, acc_write, mem_write, acc_read},
                         mem_data_out, exp_ctl);
            end
            checks++;
            if (odd) begin
                exp_addr = src + 32'(k * 4);
                if (mem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL %s mem_addr cycle %0d: got %h, want %h", name, c, mem_addr, exp_addr);
                end
                mem_data_in = data + (vary ? 32'(k) : 32'd0);
            end else begin
                exp_addr = dest + 32'(k * 4);
                exp_data = data + (vary ? 32'(k) : 32'd0);
                if (acc_addr !== exp_addr || acc_data_out !== exp_data) begin
                    errors++;
                    $display("FAIL %s acc cycle %0d: got addr=%h data=%h, want addr=%h data=%h",
                             name, c, acc_addr, acc_data_out, exp_addr, exp_data);
                end
            end
            if (disturb) begin
                src_addr = $urandom;
                dest_addr = $urandom;
                transfer_length = $urandom;
                start_transfer = (c % 2) == 0;
            end
        end
        exp_data = data + (vary ? 32'(nwords - 1) : 32'd0);
        for (int t = 0; t < trail; t++) begin
            @(negedge clk);
            checks++;
            if ({dma_busy, mem_read, acc_write} !== 3'b0 ||
                mem_addr !== src + 32'((nwords - 1) * 4) ||
                acc_addr !== dest + 32'((nwords - 1) * 4) ||
                acc_data_out !== exp_data) begin
                errors++;
                $display("FAIL %s idle_hold %0d: got busy,rd,wr=%b maddr=%h aaddr=%h adata=%h, want 000 %h %h %h",
                         name, t, {dma_busy, mem_read, acc_write}, mem_addr, acc_addr, acc_data_out,
                         src + 32'((nwords - 1) * 4), dest + 32'((nwords - 1) * 4), exp_data);
            end
        end
    endtask

    task automatic test_zero_length();
        start_transfer = 1'b0;
        @(negedge clk);
        src_addr = 32'h0000_5000;
        dest_addr = 32'h0000_6000;
        transfer_length = 32'd0;
        start_transfer = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({dma_busy, mem_read, acc_write} !== 3'b0) begin
                errors++;
                $display("FAIL zero_len cycle %0d: got busy,rd,wr=%b, want 000",
                         c, {dma_busy, mem_read, acc_write});
            end
        end
        start_transfer = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_transfer = 1'b0;
        @(negedge clk);
        src_addr = 32'h0000_3000;
        dest_addr = 32'h0000_4000;
        transfer_length = 32'd16;
        mem_data_in = 32'h77;
        start_transfer = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_3008) begin
            errors++;
            $display("FAIL reset_mid word3: got rd=%b maddr=%h, want 1 00003008", mem_read, mem_addr);
        end
        reset = 1'b0;
        start_transfer = 1'b0;
        #1;
        checks++;
        if ({dma_busy, mem_read, acc_write} !== 3'b0 || mem_addr !== 32'd0 ||
            acc_addr !== 32'd0 || acc_data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid immediate: got busy,rd,wr=%b maddr=%h aaddr=%h adata=%h, want all 0",
                     {dma_busy, mem_read, acc_write}, mem_addr, acc_addr, acc_data_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({dma_busy, mem_read, acc_write} !== 3'b0 || mem_addr !== 32'd0 || acc_addr !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid after %0d: got busy,rd,wr=%b maddr=%h aaddr=%h, want 000 0 0",
                         c, {dma_busy, mem_read, acc_write}, mem_addr, acc_addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_transfer("b2b_a", 32'h0000_0100, 32'h0000_0200, 32'd8, 32'hC0DE_0000, 2, 1'b1, 1'b0, 0);
        test_transfer("b2b_b", 32'h0000_0900, 32'h0000_0A00, 32'd12, 32'hBEEF_0000, 3, 1'b1, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_transfer("basic", 32'h4000_0000, 32'h8000_0000, 32'd32, 32'h0000_00AA, 8, 1'b0, 1'b0, 3);
        test_transfer("ceil5", 32'h0000_0100, 32'h0000_0200, 32'd5, 32'h1122_3344, 2, 1'b1, 1'b0, 2);
        test_zero_length();
        test_transfer("wrap", 32'hFFFF_FFFC, 32'h0000_0010, 32'd8, 32'h0000_5A5A, 2, 1'b1, 1'b0, 2);
        test_transfer("ignore", 32'h0000_1000, 32'h0000_2000, 32'd12, 32'h5500_0000, 3, 1'b1, 1'b1, 3);
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 The module SHALL have one parameter: BYTES_PER_WORD, default 4, address increment and byte count per transferred word.
REQ-002 The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  asynchronous active-low reset.
REQ-005 Port start_transfer  input  1  transfer request; its rising edge starts a transfer.
REQ-006 Port src_addr  input  32  memory source byte address.
REQ-007 Port dest_addr  input  32  accelerator destination byte address.
REQ-008 Port transfer_length  input  32  transfer size in bytes.
REQ-009 Port mem_data_in  input  32  memory read data, valid in the same cycle as mem_read.
REQ-010 Port dma_busy  output  1  high while a transfer is in progress.
REQ-011 Port mem_addr  output  32  memory byte address.
REQ-012 Port mem_read  output  1  memory read strobe, one cycle per word.
REQ-013 Port mem_write  output  1  memory write strobe, always 0.
REQ-014 Port mem_data_out  output  32  memory write data, always 0.
REQ-015 Port acc_addr  output  32  accelerator byte address.
REQ-016 Port acc_read  output  1  accelerator read strobe, always 0.
REQ-017 Port acc_write  output  1  accelerator write strobe, one cycle per word.
REQ-018 Port acc_data_out  output  32  accelerator write data.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The FSM SHALL have exactly three states: IDLE, READ and WRITE.
REQ-021 A registered copy of start_transfer (reset value 0) SHALL detect a rising edge: start_transfer=1 while the registered copy is 0.
REQ-022 In IDLE, a rising edge with transfer_length>0 SHALL latch src_addr, dest_addr and word count = ceil(transfer_length/BYTES_PER_WORD), clear the offset, and enter READ.
REQ-023 A rising edge with transfer_length=0 SHALL be ignored: the FSM stays in IDLE and no strobe is issued.
REQ-024 In READ, outputs SHALL be mem_read=1, mem_addr=src+offset, dma_busy=1, acc_write=0; the FSM SHALL capture mem_data_in at the closing edge and go to WRITE.
REQ-025 In WRITE, outputs SHALL be acc_write=1, acc_addr=dest+offset, acc_data_out=captured word, dma_busy=1, mem_read=0.
REQ-026 At the close of WRITE, offset SHALL increase by BYTES_PER_WORD and the word count SHALL decrement; the FSM SHALL go to READ if words remain, otherwise to IDLE.
REQ-027 Each word SHALL take exactly 2 cycles; dma_busy SHALL stay high for exactly 2*words consecutive cycles, starting the cycle after the start edge.
REQ-028 Address addition SHALL be modulo 2^32, so addresses wrap past 0xFFFFFFFC.
REQ-029 In IDLE, mem_read, acc_write and dma_busy SHALL be 0; mem_addr, acc_addr and acc_data_out SHALL hold their last values.
REQ-030 While busy, changes on start_transfer, src_addr, dest_addr and transfer_length SHALL be ignored.
REQ-031 A start_transfer level held high after completion SHALL NOT restart a transfer; a new 0->1 transition is required.
REQ-032 A rising edge coinciding with the final WRITE cycle SHALL be ignored.

Reset
REQ-033 While reset=0, the module SHALL immediately force the FSM to IDLE and all outputs, counters, latched addresses, captured data and the start history register to 0, including mid-transfer.
REQ-034 After reset deassertion, the FSM SHALL remain in IDLE until a start_transfer rising edge occurs.

Verification
REQ-035 Reset pulse mid-transfer (reset=0 for 2 cycles during word 3) -> all outputs 0 immediately; no strobe afterwards until a new start edge.
REQ-036 src=0x40000000, dest=0x80000000, len=32, mem_data_in=0xAA, start held high -> 16 busy cycles; mem_addr 0x40000000..0x4000001C; acc_addr 0x80000000..0x8000001C; acc_data_out=0xAA; no restart.
REQ-037 len=5 -> 2 words (ceil rounding), 4 busy cycles; len=0 -> dma_busy stays 0.
REQ-038 src=0xFFFFFFFC, len=8 -> mem_addr sequence 0xFFFFFFFC then 0x00000000.
REQ-039 Inputs changed and start toggled mid-transfer -> original addresses and length completed unchanged.
REQ-040 Back-to-back starts (low one cycle after done, then high) -> second transfer begins the cycle after the edge; mem_write, acc_read and mem_data_out are 0 throughout.
